// File: rtl/tc_sequencer.sv
// Job-level controller for the ternary threshold-compress unit: feeds activations
// with per-channel thresholds, captures packed bytes into a 2-entry FWFT FIFO, pads tails.
module tc_sequencer #(
    parameter int MAX_CH = 16,
    parameter int CH_AW  = $clog2(MAX_CH),
    parameter int LEN_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_we_i,
    input  logic [CH_AW-1:0] cfg_addr_i,
    input  logic [31:0]      cfg_thr_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [CH_AW:0]   nch_i,
    output logic             busy_o,
    output logic             done_o,
    input  logic             in_valid_i,
    input  logic [31:0]      in_data_i,
    output logic             in_ready_o,
    output logic             cmp_en_o,
    output logic [31:0]      cmp_data_o,
    output logic [31:0]      cmp_thr_o,
    input  logic [7:0]       cmp_byte_i,
    input  logic             cmp_ready_i,
    output logic             out_valid_o,
    output logic [7:0]       out_data_o,
    output logic             out_last_o,
    input  logic             out_ready_i
);

    typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_PAD, ST_DRAIN, ST_FLUSH, ST_WAIT} state_t;

    localparam logic [31:0]    PAD_THR = 32'h0000_0001;
    localparam logic [CH_AW:0] NCH_MAX = (CH_AW+1)'(MAX_CH);

    state_t           r_state;
    logic [2:0]       r_grp;
    logic             r_byte_pend;
    logic [CH_AW-1:0] r_ch;
    logic [CH_AW:0]   r_nch;
    logic [LEN_W-1:0] r_rem;
    logic             r_busy;
    logic             r_done;
    logic [31:0]      r_thr_mem [MAX_CH];
    logic [8:0]       r_fifo [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_cnt;

    logic             w_full, w_empty, w_cap_blk, w_in_ready, w_en;
    logic             w_push, w_pop, w_grp_wrap, w_ch_wrap;
    logic [31:0]      w_data, w_thr;
    logic [CH_AW:0]   w_nch_lat;
    logic             w_unused;

    // The group-full flag is implied by grp tracking; it is only observed externally.
    assign w_unused = cmp_ready_i;

    always_comb begin
        w_full     = (r_cnt == 2'd2);
        w_empty    = (r_cnt == 2'd0);
        w_cap_blk  = (r_grp == 3'd0) && r_byte_pend && w_full;
        w_in_ready = 1'b0;
        w_en       = 1'b0;
        w_data     = '0;
        w_thr      = '0;
        case (r_state)
            ST_RUN: begin
                w_in_ready = (r_rem != '0) && !w_cap_blk;
                w_en       = in_valid_i && w_in_ready;
                if (w_en) begin
                    w_data = in_data_i;
                    w_thr  = r_thr_mem[r_ch];
                end
            end
            ST_PAD:   w_en = 1'b1;
            ST_DRAIN: w_en = !w_full;
            ST_FLUSH: w_en = 1'b1;
            default:  w_en = 1'b0;
        endcase
        if (w_en && r_state != ST_RUN)
            w_thr = PAD_THR;
        w_push     = w_en && (r_grp == 3'd0) && r_byte_pend;
        w_pop      = !w_empty && out_ready_i;
        w_grp_wrap = (r_grp == 3'd4);
        w_ch_wrap  = ({1'b0, r_ch} == r_nch - (CH_AW+1)'(1));
        if (nch_i == '0)
            w_nch_lat = (CH_AW+1)'(1);
        else if (nch_i > NCH_MAX)
            w_nch_lat = NCH_MAX;
        else
            w_nch_lat = nch_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_grp       <= '0;
            r_byte_pend <= 1'b0;
            r_ch        <= '0;
            r_nch       <= '0;
            r_rem       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_cnt       <= '0;
            for (int unsigned i = 0; i < MAX_CH; i++)
                r_thr_mem[i] <= '0;
            for (int unsigned i = 0; i < 2; i++)
                r_fifo[i] <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE && cfg_we_i)
                r_thr_mem[cfg_addr_i] <= cfg_thr_i;

            if (w_en)
                r_grp <= w_grp_wrap ? 3'd0 : r_grp + 3'd1;
            if (w_push)
                r_byte_pend <= 1'b0;
            else if (w_en && w_grp_wrap && (r_state == ST_RUN || r_state == ST_PAD))
                r_byte_pend <= 1'b1;

            if (w_push) begin
                r_fifo[r_wptr] <= {r_state == ST_DRAIN, cmp_byte_i};
                r_wptr         <= ~r_wptr;
            end
            if (w_pop)
                r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase

            case (r_state)
                ST_IDLE: if (start_i) begin
                    r_rem   <= len_i;
                    r_nch   <= w_nch_lat;
                    r_ch    <= '0;
                    r_busy  <= 1'b1;
                    r_state <= (len_i == '0) ? ST_WAIT : ST_RUN;
                end
                ST_RUN: if (w_en) begin
                    r_rem <= r_rem - LEN_W'(1);
                    r_ch  <= w_ch_wrap ? '0 : r_ch + CH_AW'(1);
                    if (r_rem == LEN_W'(1))
                        r_state <= w_grp_wrap ? ST_DRAIN : ST_PAD;
                end
                ST_PAD:   if (w_grp_wrap) r_state <= ST_DRAIN;
                ST_DRAIN: if (w_en) r_state <= ST_FLUSH;
                // Flush completes a dummy group so the compressor counter ends at zero.
                ST_FLUSH: if (w_grp_wrap) r_state <= ST_WAIT;
                ST_WAIT: if (w_empty) begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign in_ready_o  = w_in_ready;
    assign cmp_en_o    = w_en;
    assign cmp_data_o  = w_data;
    assign cmp_thr_o   = w_thr;
    assign out_valid_o = !w_empty;
    assign out_data_o  = r_fifo[r_rptr][7:0];
    assign out_last_o  = r_fifo[r_rptr][8];

endmodule

// File: tb/tb_tc_sequencer.sv
// Scoreboard bench for tc_sequencer with a behavioural compressor and a byte-level reference model.
`timescale 1ns/1ps
module tb_tc_sequencer;
    localparam int MAX_CH = 16;
    localparam int CH_AW  = 4;
    localparam int LEN_W  = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_we = 1'b0;
    logic [CH_AW-1:0] cfg_addr = '0;
    logic [31:0]      cfg_thr = '0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len_in = '0;
    logic [CH_AW:0]   nch_in = '0;
    logic             busy, done, in_ready, cmp_en, out_valid, out_last;
    logic             in_valid = 1'b0;
    logic [31:0]      in_data = '0;
    logic [31:0]      cmp_data, cmp_thr;
    logic [7:0]       cmp_byte, out_data;
    logic             cmp_rdy;
    logic             out_ready = 1'b0;

    always #5 clk = ~clk;

    tc_sequencer #(.MAX_CH(MAX_CH), .CH_AW(CH_AW), .LEN_W(LEN_W)) dut (
        .clk_i(clk), .rst_i(rst), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_thr_i(cfg_thr),
        .start_i(start), .len_i(len_in), .nch_i(nch_in), .busy_o(busy), .done_o(done),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .cmp_en_o(cmp_en), .cmp_data_o(cmp_data), .cmp_thr_o(cmp_thr),
        .cmp_byte_i(cmp_byte), .cmp_ready_i(cmp_rdy),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_last_o(out_last), .out_ready_i(out_ready)
    );

    int          n_cmp = 0, n_err = 0;
    int          en_cnt = 0, done_cnt = 0, out_cnt = 0;
    int          bp_left = 0;
    logic [8:0]  exp_q [$];
    int          jd [$];
    logic [31:0] tbl [MAX_CH];

    function automatic int trit(input logic [31:0] d, input logic [31:0] thr);
        int di, lo, hi;
        di = $signed(d);
        lo = $signed(thr[31:16]);
        hi = $signed(thr[15:0]);
        if (di >= hi) return 1;
        if (di < lo) return -1;
        return 0;
    endfunction

    function automatic int p3(input int k);
        int r;
        r = 1;
        for (int j = 0; j < k; j++) r = r * 3;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural compressor: base-3 packing, byte presented after the 5th enable.
    int m_cnt;
    int m_acc;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt    <= 0;
            m_acc    <= 0;
            cmp_byte <= '0;
            cmp_rdy  <= 1'b0;
        end else if (cmp_en) begin
            if (m_cnt == 4) begin
                cmp_byte <= 8'(m_acc + (trit(cmp_data, cmp_thr) + 1) * p3(4));
                cmp_rdy  <= 1'b1;
                m_cnt    <= 0;
                m_acc    <= 0;
            end else begin
                m_acc   <= m_acc + (trit(cmp_data, cmp_thr) + 1) * p3(m_cnt);
                m_cnt   <= m_cnt + 1;
                cmp_rdy <= 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted output byte.
    always @(negedge clk) begin
        if (!rst) begin
            if (cmp_en) en_cnt++;
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_byte: got %0h expected none", {out_last, out_data});
                end else begin
                    chk("out_byte", {55'd0, out_last, out_data}, {55'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (bp_left > 0) begin
                out_ready = 1'b0;
                bp_left--;
            end else begin
                out_ready = ($urandom_range(3) != 0);
            end
        end
    end

    task automatic cfg_write(input int a, input logic [31:0] v);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = CH_AW'(a); cfg_thr = v;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        tbl[a] = v;
    endtask

    task automatic run_job(input int len, input int nch, input int bp, input bit busy_wr);
        int en0, d0, o0, fed, cyc, stall, nbytes, ne, acc, idx, t;
        en0 = en_cnt; d0 = done_cnt; o0 = out_cnt;
        nbytes = (len + 4) / 5;
        ne = (nch == 0) ? 1 : nch;
        for (int b = 0; b < nbytes; b++) begin
            acc = 0;
            for (int k = 0; k < 5; k++) begin
                idx = b * 5 + k;
                t = (idx < len) ? trit(jd[idx], tbl[idx % ne]) : 0;
                acc = acc + (t + 1) * p3(k);
            end
            exp_q.push_back({b == nbytes - 1, acc[7:0]});
        end
        @(posedge clk); #1;
        bp_left = bp;
        start = 1'b1; len_in = LEN_W'(len); nch_in = (CH_AW+1)'(nch);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        fed = 0; cyc = 0; stall = 0;
        while (done_cnt == d0 && cyc < 3000) begin
            in_valid = (fed < len) && ($urandom_range(3) != 0);
            if (fed < len) in_data = jd[fed];
            cfg_we = busy_wr && (cyc == 2);
            cfg_addr = '0;
            cfg_thr = 32'h7FFF_7FFF;
            @(negedge clk);
            if (in_valid && in_ready) fed++;
            if (in_valid && !in_ready) stall++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        cfg_we = 1'b0;
        if (cyc >= 3000) begin
            n_cmp++;
            n_err++;
            $display("FAIL job_timeout: got no done expected done within 3000 cycles");
        end
        repeat (2) @(negedge clk);
        chk("fed_count", 64'(fed), 64'(len));
        chk("enable_count", 64'(en_cnt - en0), 64'((len == 0) ? 0 : 5 * nbytes + 5));
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("byte_count", 64'(out_cnt - o0), 64'(nbytes));
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("busy_after_done", {63'd0, busy}, 64'd0);
        if (len == 0) chk("len0_done_latency", 64'(cyc), 64'd2);
        if (bp > 0) chk("backpressure_stall", {63'd0, stall > 0}, 64'd1);
    endtask

    initial begin
        int d0, v;
        for (int i = 0; i < MAX_CH; i++) tbl[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {50'd0, busy, done, in_ready, cmp_en, out_valid, out_last, out_data},
            64'd0);
        rst = 1'b0;

        // Basic job
        cfg_write(0, 32'hFFF6_000A);
        jd.delete();
        jd.push_back(-20); jd.push_back(0); jd.push_back(20); jd.push_back(-11); jd.push_back(10);
        run_job(5, 1, 0, 1'b0);

        // Tail padding
        jd.delete();
        for (int i = 0; i < 7; i++) jd.push_back(100);
        run_job(7, 1, 0, 1'b0);

        // Back-to-back, len 3 then 5, with a busy-time table write in the first
        jd.delete();
        for (int i = 0; i < 3; i++) jd.push_back(int'($urandom_range(60)) - 30);
        run_job(3, 1, 0, 1'b1);
        jd.delete();
        for (int i = 0; i < 5; i++) jd.push_back(int'($urandom_range(60)) - 30);
        run_job(5, 1, 0, 1'b0);

        // Channel cycling
        cfg_write(1, 32'h0000_0064);
        cfg_write(2, 32'hFF9C_FFCE);
        jd.delete();
        for (int i = 0; i < 6; i++) jd.push_back(0);
        run_job(6, 3, 0, 1'b0);

        // Backpressure
        jd.delete();
        for (int i = 0; i < 20; i++) jd.push_back(int'($urandom_range(40)) - 20);
        run_job(20, 1, 30, 1'b0);

        // Zero-length job
        jd.delete();
        run_job(0, 1, 0, 1'b0);

        // Randomized jobs
        for (int j = 0; j < 6; j++) begin
            for (int c = 0; c < 5; c++) begin
                v = int'($urandom_range(100));
                cfg_write(c, {16'(-v), 16'(int'($urandom_range(100)))});
            end
            jd.delete();
            v = int'($urandom_range(23)) + 1;
            for (int i = 0; i < v; i++) jd.push_back(int'($urandom_range(400)) - 200);
            run_job(v, int'($urandom_range(5)), 0, 1'b0);
        end

        // Reset mid-RUN
        d0 = done_cnt;
        @(posedge clk); #1;
        bp_left = 1000;
        start = 1'b1; len_in = LEN_W'(20); nch_in = (CH_AW+1)'(1);
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'd50;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_ctrl", {50'd0, busy, done, in_ready, cmp_en, out_valid, out_last, out_data},
            64'd0);
        chk("midrst_cmp", {cmp_data, cmp_thr}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bp_left = 0;
        exp_q.delete();
        for (int i = 0; i < MAX_CH; i++) tbl[i] = '0;
        repeat (4) @(negedge clk);
        chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);

        // Table must read back as zero after reset, then a fresh configured job
        jd.delete();
        for (int i = 0; i < 8; i++) jd.push_back(int'($urandom_range(20)) - 10);
        run_job(8, 2, 0, 1'b0);
        cfg_write(0, 32'hFFF6_000A);
        jd.delete();
        jd.push_back(-20); jd.push_back(0); jd.push_back(20); jd.push_back(-11); jd.push_back(10);
        run_job(5, 1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
